// File: rtl/fpr_cdb_arbiter.sv
// fpr_cdb_arbiter
//   Round-robin arbiter for the FPR common data bus. In each cycle it grants
//   at most one requesting FP execution unit. It captures that unit's ROB tag
//   and broadcasts {valid, tag, data} on fpr_cdb in the following cycle. The
//   data field is the granted unit's registered result.
//
// Ports
//   clk        : single clock, all state updates on posedge
//   reset      : synchronous, active-high
//   req_valid  : per-unit request (unit has a dispatchable entry)
//   req_ready  : per-unit grant, one-hot or zero, combinational
//   req_tag    : per-unit ROB tag, presented alongside req_valid
//   req_result : per-unit registered result, valid the cycle after grant
//   fpr_cdb    : broadcast bus, packed as {valid, tag[ROB_WIDTH-1:0], data[31:0]}
module fpr_cdb_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ROB_WIDTH = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    req_valid,
  output logic [N_REQ-1:0]                    req_ready,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0]     req_tag,
  input  logic [N_REQ-1:0][31:0]              req_result,
  output logic [ROB_WIDTH+32:0]               fpr_cdb
);

  localparam int unsigned IW = $clog2(N_REQ);

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  logic [IW-1:0]        ptr;
  logic                 gnt_vld;
  logic [IW-1:0]        gnt_idx;
  logic [ROB_WIDTH-1:0] gnt_tag;

  logic                 found;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        ptr_next;
  logic [IW-1:0]        j_idx;
  int unsigned          j;
  cdb_t                 cdb;

  // Search ptr, ptr+1, ... modulo N_REQ. The first valid requester wins.
  // Reset suppresses every grant, so no transfer can happen while it is high.
  always_comb begin
    found     = 1'b0;
    sel_idx   = '0;
    req_ready = '0;
    j         = 0;
    j_idx     = '0;
    if (!reset) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        j = int'(ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        j_idx = IW'(j);
        if (!found && req_valid[j_idx]) begin
          found          = 1'b1;
          sel_idx        = j_idx;
          req_ready[j_idx] = 1'b1;
        end
      end
    end
    ptr_next = (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_vld <= 1'b0;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt_tag <= '0;
    end else if (found) begin
      gnt_vld <= 1'b1;
      gnt_idx <= sel_idx;
      gnt_tag <= req_tag[sel_idx];
      ptr     <= ptr_next;
    end else begin
      gnt_vld <= 1'b0;
    end
  end

  // The data field is a mux over the units' registered outputs. The unit
  // granted last cycle holds its result in this cycle.
  always_comb begin
    cdb.valid = gnt_vld;
    cdb.tag   = gnt_tag;
    cdb.data  = req_result[gnt_idx];
  end

  assign fpr_cdb = cdb;

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
module tb_fpr_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 6;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N-1:0][RW-1:0]     req_tag;
  logic [N-1:0][31:0]       req_result;
  logic [RW+32:0]           fpr_cdb;

  fpr_cdb_arbiter #(.N_REQ(N), .ROB_WIDTH(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .req_result (req_result),
    .fpr_cdb    (fpr_cdb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: priority pointer plus the single pending broadcast.
  int m_ptr   = 0;
  bit m_vld   = 1'b0;
  int m_idx   = 0;
  int m_tag   = 0;
  int exp_gnt = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][31:0] rand_res();
    logic [N-1:0][31:0] r;
    for (int i = 0; i < N; i++) r[i] = $urandom;
    return r;
  endfunction

  // Drive one cycle's inputs. Then compare the broadcast and the grant
  // against the model.
  task automatic apply(input bit rst, input logic [N-1:0] v,
                       input logic [N-1:0][RW-1:0] tags,
                       input logic [N-1:0][31:0] res);
    logic [N-1:0] exp_ready;
    reset = rst; req_valid = v; req_tag = tags; req_result = res;
    #1;
    check("cdb_valid", 64'(fpr_cdb[RW+32]), 64'(m_vld));
    if (m_vld) begin
      check("cdb_tag",  64'(fpr_cdb[RW+31:32]), 64'(m_tag));
      check("cdb_data", 64'(fpr_cdb[31:0]),     64'(res[m_idx]));
    end
    exp_gnt = -1;
    if (!rst)
      for (int k = 0; k < N; k++)
        if (exp_gnt < 0 && v[(m_ptr + k) % N]) exp_gnt = (m_ptr + k) % N;
    exp_ready = '0;
    if (exp_gnt >= 0) exp_ready[exp_gnt] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
  endtask

  task automatic advance();
    if (reset) begin
      m_vld = 1'b0;
      m_ptr = 0;
    end else if (exp_gnt >= 0) begin
      m_vld = 1'b1;
      m_idx = exp_gnt;
      m_tag = int'(req_tag[exp_gnt]);
      m_ptr = (exp_gnt + 1) % N;
    end else begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0][RW-1:0] t;
  logic [N-1:0][31:0]   r;
  logic [N-1:0]         pv;
  logic [N-1:0][RW-1:0] pt;
  int                   wt [N];
  bit                   rst;

  initial begin
    reset = 1'b1; req_valid = '0; req_tag = '0; req_result = '0;
    t = '0; pv = '0; pt = '0;
    for (int i = 0; i < N; i++) wt[i] = 0;
    @(posedge clk); #1;

    // Reset with nothing requesting.
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, '0, t, rand_res());
      check("rst_ready", 64'(req_ready), 64'(0));
      advance();
    end

    // Single request from unit 2 with tag 5.
    t = '0; t[2] = RW'(5);
    apply(1'b0, 4'b0100, t, rand_res());
    check("single_ready", 64'(req_ready), 64'(4'b0100));
    advance();
    r = rand_res(); r[2] = 32'h3F800000;
    apply(1'b0, '0, t, r);
    check("single_cdb", 64'(fpr_cdb), 64'({1'b1, 6'd5, 32'h3F800000}));
    advance();
    apply(1'b0, '0, t, rand_res());
    check("single_after", 64'(fpr_cdb[RW+32]), 64'(0));
    advance();

    // The pointer is now 3. Units 0 and 3 request, so 3 wins and the pointer wraps.
    apply(1'b0, 4'b1001, t, rand_res());
    check("wrap_ready3", 64'(req_ready), 64'(4'b1000));
    advance();
    apply(1'b0, 4'b1001, t, rand_res());
    check("wrap_ready0", 64'(req_ready), 64'(4'b0001));
    advance();

    // Reset the pointer to 0. Then all four units request continuously.
    apply(1'b1, '0, t, rand_res());
    advance();
    for (int i = 0; i < N; i++) t[i] = RW'(10 + i);
    for (int c = 0; c < 6; c++) begin
      apply(1'b0, 4'b1111, t, rand_res());
      check("rr_ready", 64'(req_ready), 64'(1 << (c % N)));
      if (c > 0) check("rr_tag", 64'(fpr_cdb[RW+31:32]), 64'(10 + (c - 1) % N));
      advance();
    end

    // Grant unit 1 (pointer is 2, unit 1 alone), then reset the next cycle.
    t = '0; t[1] = RW'(7);
    apply(1'b0, 4'b0010, t, rand_res());
    check("mid_ready", 64'(req_ready), 64'(4'b0010));
    advance();
    apply(1'b1, 4'b0001, t, rand_res());
    check("mid_cdb_vld", 64'(fpr_cdb[RW+32]), 64'(1));
    check("mid_cdb_tag", 64'(fpr_cdb[RW+31:32]), 64'(7));
    check("mid_rst_ready", 64'(req_ready), 64'(0));
    advance();
    apply(1'b0, 4'b1111, t, rand_res());
    check("post_rst_vld", 64'(fpr_cdb[RW+32]), 64'(0));
    check("post_rst_ptr0", 64'(req_ready), 64'(4'b0001));
    advance();

    // Random traffic. A request stays up with the same tag until it is granted.
    pv = '0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pt[i] = RW'($urandom);
          wt[i] = 0;
        end
      apply(rst, pv, pt, rand_res());
      for (int i = 0; i < N; i++) begin
        if (rst) wt[i] = 0;
        else if (pv[i]) begin
          if (exp_gnt == i) pv[i] = 1'b0;
          else begin
            wt[i]++;
            check("fair_wait", 64'(wt[i] > N - 1), 64'(0));
          end
        end
      end
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
